// File: rtl/ps2_key_event_queue_pkg.sv
// Shared definitions for the PS/2 key event queue: prefixes, register map, event word, decoder states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ps2_pkg;
   localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
   localparam logic [31:0] KB_DATA_ADDR   = 32'hFFFF0000;
   localparam logic [31:0] KB_STAT_ADDR   = 32'hFFFF0004;

   // One decoded key event: break flag, extended flag, raw scan code.
   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } kb_event_t;

   localparam int KB_EVENT_W = $bits(kb_event_t);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kb_dec_state_t;
endpackage

// File: rtl/ps2_key_event_queue_fifo.sv
// Generic synchronous FIFO with push/pop, full/empty and occupancy count.
// Latency: a push is visible at head/count on the next edge; head is combinational from storage.
// Backpressure: a push while full is accepted only when a pop in the same cycle frees a slot; otherwise it is ignored.
module kb_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Storage write; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two; count tracks net occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end
endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code folder and memory-mapped event queue: E0/F0 prefixes fold into {brk, ext, code} events.
// Latency: completing byte in cycle N is queued (count, irq, leds) in N+1; reads return DataOut on the next edge.
// Backpressure: none upstream; pushes into a full queue are dropped and latch a sticky overflow flag.
module ps2_key_event_queue
   import ps2_pkg::*;
#(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] DATA_ADDR = KB_DATA_ADDR,
   parameter logic [31:0] STAT_ADDR = KB_STAT_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        MemRead,
   input  logic [31:0] Address,
   output logic [31:0] DataOut,
   output logic        irq,
   output logic [7:0]  leds
);
   localparam int CW = $clog2(DEPTH) + 1;

   kb_dec_state_t   state;
   kb_event_t       ev;
   logic            ev_push;
   logic            is_prefix;

   kb_event_t       head;
   logic            full;
   logic            empty;
   logic [CW-1:0]   count;
   logic [6:0]      count7;

   logic            hit_data;
   logic            hit_stat;
   logic            hit_data_q;
   logic            hit_stat_q;
   logic            pop_req;
   logic            stat_req;
   logic            drop;
   logic            overflow;

   assign is_prefix = (byte_data == PS2_PREFIX_EXT) || (byte_data == PS2_PREFIX_BRK);

   // Build the event for a completing (non-prefix) byte from the flags the current state carries.
   always_comb begin
      ev.brk  = 1'b0;
      ev.ext  = 1'b0;
      ev.code = byte_data;
      ev_push = byte_valid && !is_prefix;
      unique case (state)
         EXT:     ev.ext = 1'b1;
         BRK:     ev.brk = 1'b1;
         EXT_BRK: begin
            ev.ext = 1'b1;
            ev.brk = 1'b1;
         end
         default: ;
      endcase
   end

   // Decoder FSM; leds follows every completed event, whether or not the queue had room.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         leds  <= 8'h00;
      end else if (byte_valid) begin
         if (!is_prefix) leds <= byte_data;
         unique case (state)
            IDLE: begin
               if (byte_data == PS2_PREFIX_EXT)      state <= EXT;
               else if (byte_data == PS2_PREFIX_BRK) state <= BRK;
            end
            EXT: begin
               if (byte_data == PS2_PREFIX_BRK)      state <= EXT_BRK;
               else if (byte_data != PS2_PREFIX_EXT) state <= IDLE;
            end
            BRK: begin
               if (byte_data == PS2_PREFIX_EXT)      state <= EXT_BRK;
               else if (byte_data != PS2_PREFIX_BRK) state <= IDLE;
            end
            EXT_BRK: begin
               if (!is_prefix) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   kb_event_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (KB_EVENT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (ev_push),
      .push_data (ev),
      .pop       (pop_req),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   assign count7   = 7'(count);
   assign irq      = !empty;
   assign hit_data = MemRead && (Address == DATA_ADDR);
   assign hit_stat = MemRead && (Address == STAT_ADDR);
   // Only the first cycle of a held load acts, so a multi-cycle load consumes one event.
   assign pop_req  = hit_data && !hit_data_q;
   assign stat_req = hit_stat && !hit_stat_q;
   assign drop     = ev_push && full && !(pop_req && !empty);

   // Read data register, hit edge detect and sticky overflow (a drop beats a status clear).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         DataOut    <= 32'h0;
         hit_data_q <= 1'b0;
         hit_stat_q <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         hit_data_q <= hit_data;
         hit_stat_q <= hit_stat;
         if (pop_req)                   DataOut <= empty ? 32'h0 : {1'b1, 21'b0, head};
         else if (stat_req)             DataOut <= {23'b0, overflow, 1'b0, count7};
         else if (!hit_data && !hit_stat) DataOut <= 32'h0;
         if (drop)          overflow <= 1'b1;
         else if (stat_req) overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Self-checking bench for ps2_key_event_queue: directed scenarios then randomized traffic vs a queue model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: none; the bench drives a fresh input set every cycle.
module tb_ps2_key_event_queue;
   localparam int          DEPTH = 8;
   localparam logic [31:0] DA    = 32'hFFFF0000;
   localparam logic [31:0] SA    = 32'hFFFF0004;

   logic        clk = 1'b0;
   logic        reset;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        MemRead;
   logic [31:0] Address;
   logic [31:0] DataOut;
   logic        irq;
   logic [7:0]  leds;

   int checks   = 0;
   int failures = 0;

   // Reference model state: event queue, pending prefix flags, overflow, last leds/DataOut, previous hits.
   logic [9:0]  mq[$];
   bit          m_ext, m_brk, m_ovf, m_pd, m_ps;
   logic [7:0]  m_leds;
   logic [31:0] m_dout;

   always #5 clk = ~clk;

   ps2_key_event_queue #(.DEPTH(DEPTH), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .MemRead    (MemRead),
      .Address    (Address),
      .DataOut    (DataOut),
      .irq        (irq),
      .leds       (leds)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_pd = 0; m_ps = 0;
      m_leds = 8'h00; m_dout = 32'h0;
   endtask

   // One clock of behaviour: reads act on pre-edge state, then a completed event joins the queue.
   task automatic model_step(input bit bv, input logic [7:0] bd, input bit mr, input logic [31:0] addr);
      bit hd, hs;
      int n;
      hd = mr && (addr == DA);
      hs = mr && (addr == SA);
      n  = mq.size();
      if (hd && !m_pd) begin
         if (n > 0) begin
            m_dout = {1'b1, 21'b0, mq[0]};
            void'(mq.pop_front());
         end else m_dout = 32'h0;
      end else if (hs && !m_ps) begin
         m_dout = {23'b0, m_ovf, 1'b0, 7'(n)};
         m_ovf  = 0;
      end else if (!hd && !hs) m_dout = 32'h0;
      m_pd = hd;
      m_ps = hs;
      if (bv) begin
         if (bd == 8'hE0) m_ext = 1;
         else if (bd == 8'hF0) m_brk = 1;
         else begin
            m_leds = bd;
            if (mq.size() < DEPTH) mq.push_back({m_brk, m_ext, bd});
            else m_ovf = 1;
            m_ext = 0;
            m_brk = 0;
         end
      end
   endtask

   task automatic cycle(input bit bv, input logic [7:0] bd, input bit mr, input logic [31:0] addr);
      byte_valid = bv;
      byte_data  = bd;
      MemRead    = mr;
      Address    = addr;
      @(posedge clk);
      model_step(bv, bd, mr, addr);
      #1;
      chk("dataout", DataOut, m_dout);
      chk("irq", {31'b0, irq}, {31'b0, mq.size() != 0});
      chk("leds", {24'b0, leds}, {24'b0, m_leds});
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b0, 32'h0);
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 32'h0);
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] v);
      cycle(1'b0, 8'h00, 1'b1, addr);
      v = DataOut;
      idle();
   endtask

   task automatic do_reset(input bit early);
      byte_valid = 0; byte_data = 8'h00; MemRead = 0; Address = 32'h0;
      reset = 1'b1;
      #2;
      if (early) begin
         chk("rst_async_dataout", DataOut, 32'h0);
         chk("rst_async_irq", {31'b0, irq}, 32'h0);
         chk("rst_async_leds", {24'b0, leds}, 32'h0);
      end
      @(posedge clk);
      #1;
      chk("rst_dataout", DataOut, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_leds", {24'b0, leds}, 32'h0);
      reset = 1'b0;
      model_clear();
   endtask

   initial begin
      logic [31:0] v;
      bit          rbv, rmr;
      logic [7:0]  rbd;
      logic [31:0] rad;

      model_clear();
      do_reset(1'b0);
      idle();

      // Single make code, pop it, then read empty.
      send(8'h1C);
      chk("t1_irq", {31'b0, irq}, 32'h1);
      chk("t1_leds", {24'b0, leds}, 32'h1C);
      rd(DA, v);
      chk("t1_read", v, 32'h8000001C);
      chk("t1_irq_clear", {31'b0, irq}, 32'h0);
      rd(DA, v);
      chk("t1_read_empty", v, 32'h0);

      // Extended break sequence folds into one event.
      send(8'hE0); send(8'hF0); send(8'h74);
      rd(SA, v);
      chk("t2_status", v, 32'h00000001);
      rd(DA, v);
      chk("t2_read", v, 32'h80000374);

      // Overflow on the ninth event, sticky until status read.
      for (int i = 1; i <= 9; i++) send(8'(i));
      rd(SA, v);
      chk("t3_status_ovf", v, 32'h00000108);
      rd(SA, v);
      chk("t3_status_clr", v, 32'h00000008);
      for (int i = 1; i <= 8; i++) begin
         rd(DA, v);
         chk("t3_drain", v, 32'h80000000 | 32'(i));
      end

      // Push and pop in the same cycle with one event queued.
      send(8'h15);
      cycle(1'b1, 8'h16, 1'b1, DA);
      chk("t4_old_event", DataOut, 32'h80000015);
      idle();
      rd(SA, v);
      chk("t4_count", v, 32'h00000001);
      rd(DA, v);
      chk("t4_new_event", v, 32'h80000016);

      // A load held for four cycles pops once.
      send(8'h21); send(8'h22);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, DA);
      chk("t5_held", DataOut, 32'h80000021);
      idle();
      rd(SA, v);
      chk("t5_count", v, 32'h00000001);
      rd(DA, v);
      chk("t5_rest", v, 32'h80000022);

      // Reset after a lone E0 discards the prefix.
      send(8'hE0);
      do_reset(1'b1);
      send(8'h75);
      rd(DA, v);
      chk("t6_after_reset", v, 32'h80000075);

      // Full queue with simultaneous pop accepts the push without overflow.
      for (int i = 0; i < 8; i++) send(8'h40 + 8'(i));
      cycle(1'b1, 8'h5A, 1'b1, DA);
      chk("t7_pop_full", DataOut, 32'h80000040);
      idle();
      rd(SA, v);
      chk("t7_no_ovf", v, 32'h00000008);
      for (int i = 0; i < 7; i++) rd(DA, v);
      chk("t7_seventh", v, 32'h80000047);
      rd(DA, v);
      chk("t7_last", v, 32'h8000005A);

      // Empty queue with simultaneous push and pop: pop reads empty, push lands.
      cycle(1'b1, 8'h33, 1'b1, DA);
      chk("t8_empty_pop", DataOut, 32'h0);
      idle();
      rd(DA, v);
      chk("t8_landed", v, 32'h80000033);

      // Randomized traffic against the model.
      rmr = 0;
      rad = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         rbv = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0:       rbd = 8'hE0;
            1:       rbd = 8'hF0;
            default: rbd = 8'($urandom);
         endcase
         if ($urandom_range(0, 1) == 0) begin
            rmr = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 2))
               0:       rad = DA;
               1:       rad = SA;
               default: rad = 32'($urandom);
            endcase
         end
         cycle(rbv, rbd, rmr, rad);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
